// File: rtl/viterbi_acs_k3.sv
// Add-compare-select stage for a rate-1/2, K=3 Viterbi decoder (G0=111, G1=101).
// Keeps four normalised path metrics, emits per-state survivor decisions and
// flags the last symbol of each traceback block.
module viterbi_acs_k3 #(
  parameter int PM_W    = 4,
  parameter int INIT_PM = 4,
  parameter int TB_LEN  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        in,
  output logic [3:0]        dec,
  output logic              dec_valid,
  output logic [1:0]        best_state,
  output logic [4*PM_W-1:0] pm,
  output logic              blk_end
);

  localparam int            CNT_W   = $clog2(TB_LEN);
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(INIT_PM);
  localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_LEN - 1);

  logic [PM_W-1:0]  r_pm [4];
  logic [3:0]       r_dec;
  logic             r_dec_valid;
  logic [1:0]       r_best;
  logic             r_blk_end;
  logic [CNT_W-1:0] r_cnt;

  logic [PM_W-1:0]  w_sel  [4];
  logic [PM_W-1:0]  w_norm [4];
  logic [3:0]       w_dec;
  logic [PM_W-1:0]  w_min;
  logic [1:0]       w_best;
  logic             w_last;

  // Per next-state ns={u,a}: compare the two predecessors {a,0} and {a,1}.
  for (genvar gi = 0; gi < 4; gi++) begin : g_acs
    localparam int   P0 = 2 * (gi % 2);
    localparam int   P1 = P0 + 1;
    localparam logic U  = 1'(gi / 2);
    localparam logic A  = 1'(gi % 2);
    // Expected encoder outputs {c0,c1} on each branch into this state.
    localparam logic [1:0] SYM0 = {U ^ A, U};
    localparam logic [1:0] SYM1 = {U ^ A ^ 1'b1, U ^ 1'b1};

    logic [1:0]    w_x0, w_x1;
    logic [PM_W:0] w_cand0, w_cand1;
    logic [PM_W-1:0] w_sat0, w_sat1;

    assign w_x0    = in ^ SYM0;
    assign w_x1    = in ^ SYM1;
    assign w_cand0 = {1'b0, r_pm[P0]} + (PM_W+1)'(w_x0[1]) + (PM_W+1)'(w_x0[0]);
    assign w_cand1 = {1'b0, r_pm[P1]} + (PM_W+1)'(w_x1[1]) + (PM_W+1)'(w_x1[0]);
    assign w_sat0  = w_cand0[PM_W] ? PM_MAX : w_cand0[PM_W-1:0];
    assign w_sat1  = w_cand1[PM_W] ? PM_MAX : w_cand1[PM_W-1:0];

    // Ties go to the {a,0} predecessor.
    assign w_dec[gi]  = (w_sat1 < w_sat0);
    assign w_sel[gi]  = w_dec[gi] ? w_sat1 : w_sat0;
    assign w_norm[gi] = w_sel[gi] - w_min;

    assign pm[PM_W*gi +: PM_W] = r_pm[gi];
  end

  // Find the minimum selected metric and the lowest state index holding it.
  always_comb begin
    w_min  = w_sel[0];
    w_best = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (w_sel[i] < w_min) begin
        w_min  = w_sel[i];
        w_best = 2'(i);
      end
    end
  end

  assign w_last = (r_cnt == CNT_LAST);

  // Register metrics, decisions and block counter; flush mirrors reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pm[0]     <= '0;
      r_pm[1]     <= PM_INIT;
      r_pm[2]     <= PM_INIT;
      r_pm[3]     <= PM_INIT;
      r_dec       <= '0;
      r_dec_valid <= 1'b0;
      r_best      <= '0;
      r_blk_end   <= 1'b0;
      r_cnt       <= '0;
    end else if (flush) begin
      r_pm[0]     <= '0;
      r_pm[1]     <= PM_INIT;
      r_pm[2]     <= PM_INIT;
      r_pm[3]     <= PM_INIT;
      r_dec       <= '0;
      r_dec_valid <= 1'b0;
      r_best      <= '0;
      r_blk_end   <= 1'b0;
      r_cnt       <= '0;
    end else if (in_valid) begin
      for (int i = 0; i < 4; i++) begin
        r_pm[i] <= w_norm[i];
      end
      r_dec       <= w_dec;
      r_dec_valid <= 1'b1;
      r_best      <= w_best;
      r_blk_end   <= w_last;
      r_cnt       <= w_last ? '0 : r_cnt + CNT_W'(1);
    end else begin
      r_dec_valid <= 1'b0;
      r_blk_end   <= 1'b0;
    end
  end

  assign dec        = r_dec;
  assign dec_valid  = r_dec_valid;
  assign best_state = r_best;
  assign blk_end    = r_blk_end;

endmodule

// File: tb/tb_viterbi_acs_k3.sv
// Randomised bench for viterbi_acs_k3 against a trellis-level reference model.
module tb_viterbi_acs_k3;

  localparam int PM_W    = 4;
  localparam int INIT_PM = 4;
  localparam int TB_LEN  = 16;
  localparam int PM_MAX  = (1 << PM_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic [1:0]        in_sym;
  logic [3:0]        dec;
  logic              dec_valid;
  logic [1:0]        best_state;
  logic [4*PM_W-1:0] pm;
  logic              blk_end;

  viterbi_acs_k3 #(.PM_W(PM_W), .INIT_PM(INIT_PM), .TB_LEN(TB_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in         (in_sym),
    .dec        (dec),
    .dec_valid  (dec_valid),
    .best_state (best_state),
    .pm         (pm),
    .blk_end    (blk_end)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int n_txn   = 0;

  // Reference model state
  int m_pm [4];
  int m_dec, m_best, m_dv, m_be, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_pm[0] = 0;
    m_pm[1] = INIT_PM;
    m_pm[2] = INIT_PM;
    m_pm[3] = INIT_PM;
    m_dec = 0; m_best = 0; m_dv = 0; m_be = 0; m_cnt = 0;
  endfunction

  // One trellis step: for each next state pick the cheaper predecessor path.
  function automatic void m_symbol(input int sym);
    int np [4];
    int cand [2];
    int nd, mn;
    nd = 0;
    for (int ns = 0; ns < 4; ns++) begin
      int u, a;
      u = ns >> 1;
      a = ns & 1;
      for (int b = 0; b < 2; b++) begin
        int p, c0, c1, bm;
        p  = a * 2 + b;
        c0 = u ^ (p >> 1) ^ (p & 1);
        c1 = u ^ (p & 1);
        bm = (((sym >> 1) & 1) != c0 ? 1 : 0) + ((sym & 1) != c1 ? 1 : 0);
        cand[b] = m_pm[p] + bm;
        if (cand[b] > PM_MAX) cand[b] = PM_MAX;
      end
      if (cand[1] < cand[0]) begin
        np[ns] = cand[1];
        nd |= (1 << ns);
      end else begin
        np[ns] = cand[0];
      end
    end
    mn = np[0];
    for (int s = 1; s < 4; s++) if (np[s] < mn) mn = np[s];
    m_best = 0;
    for (int s = 3; s >= 0; s--) if (np[s] == mn) m_best = s;
    for (int s = 0; s < 4; s++) m_pm[s] = np[s] - mn;
    m_dec = nd;
    m_dv  = 1;
    m_be  = (m_cnt == TB_LEN - 1) ? 1 : 0;
    m_cnt = (m_cnt + 1) % TB_LEN;
  endfunction

  function automatic logic [4*PM_W-1:0] m_pack();
    logic [4*PM_W-1:0] r;
    for (int s = 0; s < 4; s++) r[PM_W*s +: PM_W] = PM_W'(m_pm[s]);
    return r;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".dv"},   32'(dec_valid),  32'(m_dv));
    chk({tag, ".pm"},   32'(pm),         32'(m_pack()));
    chk({tag, ".dec"},  32'(dec),        32'(m_dec));
    chk({tag, ".best"}, 32'(best_state), 32'(m_best));
    chk({tag, ".be"},   32'(blk_end),    32'(m_be));
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic cycle(input logic v, input logic f, input logic [1:0] s, input string tag);
    in_valid = v;
    flush    = f;
    in_sym   = s;
    @(posedge clk);
    #1;
    if (f)      m_reset();
    else if (v) m_symbol(int'(s));
    else begin
      m_dv = 0;
      m_be = 0;
    end
    n_txn++;
    $display("txn %0d %s v=%b f=%b in=%b -> dv=%b pm=%h dec=%b best=%0d be=%b",
             n_txn, tag, v, f, s, dec_valid, pm, dec, best_state, blk_end);
    check_all(tag);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Pulse the asynchronous reset between clock edges and check it lands at once.
  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
    #1;
    m_reset();
    check_all("arst");
    #1;
    reset = 1'b1;
  endtask

  logic [1:0] enc_syms [6];
  int         enc_states [6];
  int         pulses, first_pulse;

  initial begin
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_sym   = 2'b00;
    m_reset();
    @(posedge clk);
    #1;
    check_all("rst0");
    reset = 1'b1;

    // Two zero symbols from reset, then idle cycles must hold
    cycle(1'b1, 1'b0, 2'b00, "t1");
    chk("t1.pm_const", 32'(pm), 32'h5250);
    cycle(1'b1, 1'b0, 2'b00, "t2");
    chk("t2.pm_const", 32'(pm), 32'h3230);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'b11, "t2idle");
    chk("t2.hold_const", 32'(pm), 32'h3230);

    // Single 11 symbol from reset
    do_reset();
    cycle(1'b1, 1'b0, 2'b11, "t3");
    chk("t3.pm_const", 32'(pm), 32'h5052);
    chk("t3.best_const", 32'(best_state), 32'd2);

    // Clean encoded stream: the true state stays at metric 0
    enc_syms   = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    enc_states = '{2, 1, 2, 3, 1, 0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, enc_syms[i], "t4");
      chk("t4.path_pm", 32'(pm[PM_W*enc_states[i] +: PM_W]), 32'd0);
    end
    chk("t4.final_best", 32'(best_state), 32'd0);
    // Same stream with one bit flipped
    do_reset();
    for (int i = 0; i < 6; i++) begin
      logic [1:0] s;
      s = enc_syms[i];
      if (i == 2) s[1] = ~s[1];
      cycle(1'b1, 1'b0, s, "t4f");
    end

    // Block boundary pulses over 2*TB_LEN+3 back-to-back symbols
    do_reset();
    pulses = 0;
    first_pulse = 0;
    for (int i = 1; i <= 2 * TB_LEN + 3; i++) begin
      cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), "t5");
      if (blk_end) begin
        pulses++;
        if (first_pulse == 0) first_pulse = i;
      end
    end
    chk("t5.pulses", 32'(pulses), 32'd2);
    chk("t5.first", 32'(first_pulse), 32'(TB_LEN));

    // Flush with a simultaneous symbol mid-block restarts the block
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), "t6");
    cycle(1'b1, 1'b1, 2'b11, "t6flush");
    chk("t6.pm_const", 32'(pm), 32'h4440);
    for (int i = 1; i <= TB_LEN; i++) begin
      cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), "t6post");
      chk("t6.blk_pos", 32'(blk_end), (i == TB_LEN) ? 32'd1 : 32'd0);
    end

    // Random mix of symbols, gaps, flushes and async resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 63));
      if (r == 0) do_reset();
      cycle(($urandom_range(0, 3) != 0), (r == 1 || r == 2), 2'($urandom_range(0, 3)), "rnd");
    end

    // Async reset mid-block, then confirm the counter restarted
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), "t7");
    do_reset();
    for (int i = 0; i < TB_LEN; i++) cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), "t7post");
    chk("t7.blk_end", 32'(blk_end), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
